// File: rtl/nand_arb_pkg.sv
// nand_arb_pkg
// Shared definitions for the NAND arbiter: requester count, FSM state
// encoding, the round-robin pointer reset value and the round-robin pick
// helper used by the top-level selection logic.
package nand_arb_pkg;

    // Number of requesters sharing the NAND unit.
    localparam int N = 4;

    // Width of a requester index.
    localparam int GID_W = 2;

    // The pointer resets to the last requester so that the first scan after
    // reset starts at requester 0.
    localparam logic [GID_W-1:0] PTR_RST = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Round-robin pick: the first set request bit when scanning upward from
    // (ptr + 1) mod 4. The result is only meaningful when req is non-zero.
    function automatic logic [GID_W-1:0] rr_pick(input logic [N-1:0]     req,
                                                 input logic [GID_W-1:0] ptr);
        logic [GID_W-1:0] idx;
        logic             found;
        rr_pick = '0;
        found   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            // Two-bit wrap-around performs the mod-4 step for free.
            idx = ptr + GID_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/nand2_unit.sv
// nand2_unit
// The single shared two-input NAND evaluator.
// Ports:
//   i_a, i_b : operands
//   o_y      : ~(i_a & i_b)
module nand2_unit (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);

    assign o_y = ~(i_a & i_b);

endmodule

// File: rtl/nand_arbiter.sv
// nand_arbiter
// Round-robin arbiter giving N requesters turns on one shared NAND unit.
// A grant latches the winner's operands, the next cycle evaluates them and
// loads the winner's result bit, then the block holds an acknowledge until
// the winner drops its request (four-phase handshake).
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous active-high reset
//   req[i]   : requester i wants one NAND evaluation
//   a[i],b[i]: operands of requester i
//   ack[i]   : registered acknowledge, high while requester i is in ACK
//   z[i]     : result of requester i's last served request
//   busy     : high whenever the FSM is not idle
//   grant_id : index of the requester currently or last served
module nand_arbiter
    import nand_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     z,
    output logic             busy,
    output logic [GID_W-1:0] grant_id
);

    state_t           r_state;
    logic [GID_W-1:0] r_ptr;
    logic [GID_W-1:0] r_gid;
    logic [N-1:0]     r_ack;
    logic [N-1:0]     r_z;
    logic             r_op_a;
    logic             r_op_b;

    logic [GID_W-1:0] w_sel;
    logic             w_any;
    logic             w_nand;

    // Combinational round-robin selection, consumed only in IDLE.
    always_comb begin
        w_any = |req;
        w_sel = rr_pick(req, r_ptr);
    end

    nand2_unit u_nand (
        .i_a (r_op_a),
        .i_b (r_op_b),
        .o_y (w_nand)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= PTR_RST;
            r_gid   <= '0;
            r_ack   <= '0;
            r_z     <= '0;
            r_op_a  <= 1'b0;
            r_op_b  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        // Operands are captured here so later changes on
                        // a/b cannot disturb the evaluation.
                        r_op_a  <= a[w_sel];
                        r_op_b  <= b[w_sel];
                        r_gid   <= w_sel;
                        r_ptr   <= w_sel;
                        r_state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    // Evaluation always completes, even if req was dropped.
                    r_z[r_gid] <= w_nand;
                    r_ack      <= {{(N-1){1'b0}}, 1'b1} << r_gid;
                    r_state    <= ST_ACK;
                end
                ST_ACK: begin
                    if (!req[r_gid]) begin
                        r_ack   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ack   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign z        = r_z;
    assign grant_id = r_gid;
    assign busy     = (r_state != ST_IDLE);

endmodule
